// File: rtl/ps2_key_pkg.sv
// ---------------------------------------------------------------------------
// ps2_key_pkg
// Shared definitions for the PS/2 key filter:
//   - scan-code constants (prefixes, arrows, enter, esc, WASD)
//   - parser state encoding
//   - held_keys bit indices and key lookup/encode helpers
// Optional build macro: PS2_WASD_EN (W/S/A/D alias the arrow keys).
// ---------------------------------------------------------------------------
package ps2_key_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    // Bit positions inside held_keys = {esc,enter,right,left,down,up}
    localparam logic [2:0] KEY_UP    = 3'd0;
    localparam logic [2:0] KEY_DOWN  = 3'd1;
    localparam logic [2:0] KEY_LEFT  = 3'd2;
    localparam logic [2:0] KEY_RIGHT = 3'd3;
    localparam logic [2:0] KEY_ENTER = 3'd4;
    localparam logic [2:0] KEY_ESC   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } parseState_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } keyHit_t;

    // Map an (extended, code) pair onto a held_keys index.
    function automatic keyHit_t lookupKey(input logic ext, input logic [7:0] code);
        keyHit_t r;
        r.hit = 1'b1;
        r.idx = KEY_UP;
        if (ext) begin
            case (code)
                SC_UP:    r.idx = KEY_UP;
                SC_DOWN:  r.idx = KEY_DOWN;
                SC_LEFT:  r.idx = KEY_LEFT;
                SC_RIGHT: r.idx = KEY_RIGHT;
                default:  r.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_ENTER: r.idx = KEY_ENTER;
                SC_ESC:   r.idx = KEY_ESC;
`ifdef PS2_WASD_EN
                SC_W:     r.idx = KEY_UP;
                SC_S:     r.idx = KEY_DOWN;
                SC_A:     r.idx = KEY_LEFT;
                SC_D:     r.idx = KEY_RIGHT;
`endif
                default:  r.hit = 1'b0;
            endcase
        end
        return r;
    endfunction

    // Code handed to the consumer for a key; aliases collapse onto the arrow code.
    function automatic logic [7:0] keyCode(input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            KEY_UP:    c = SC_UP;
            KEY_DOWN:  c = SC_DOWN;
            KEY_LEFT:  c = SC_LEFT;
            KEY_RIGHT: c = SC_RIGHT;
            KEY_ENTER: c = SC_ENTER;
            KEY_ESC:   c = SC_ESC;
            default:   c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// ---------------------------------------------------------------------------
// ps2_key_fifo
// Small synchronous FIFO holding accepted key codes.
// Ports:
//   clock, reset      clock / asynchronous active-high reset
//   push, dataIn      write request and data (taken when not full, or when
//                     a pop happens in the same cycle)
//   pop               read request (ignored when empty)
//   dataOut           head entry (valid when not empty)
//   full, empty       status
//   count             number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ps2_key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         dataIn,
    output logic [WIDTH-1:0]         dataOut,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign doPop   = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign doPush  = push && (!full || doPop);
    assign dataOut = mem[rdPtr];

    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr] <= dataIn;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_filter.sv
// ---------------------------------------------------------------------------
// ps2_key_filter
// Cleans the raw PS/2 byte stream for the game controller: decodes E0/F0
// prefixes, suppresses typematic repeats, buffers new make codes and
// releases them one pulse at a time while the consumer is idle.
// Ports:
//   clock, reset       50 MHz clock / asynchronous active-high reset
//   ps2_key_pressed    1-cycle strobe, new byte on ps2_key_data
//   ps2_key_data       raw scan byte
//   accept_en          consumer idle; a key may be issued this cycle
//   key_pressed        1-cycle strobe to the consumer
//   key_data           make code (E0 stripped), holds between pulses
//   fifo_count         number of buffered keys
//   overflow           sticky: an accepted key was dropped on a full buffer
//   held_keys          {esc,enter,right,left,down,up} currently held
// Optional build macro: PS2_WASD_EN (W/S/A/D alias the arrow keys).
// ---------------------------------------------------------------------------
module ps2_key_filter
    import ps2_key_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int PREFIX_TIMEOUT = 1_000_000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ps2_key_pressed,
    input  logic [7:0]                    ps2_key_data,
    input  logic                          accept_en,
    output logic                          key_pressed,
    output logic [7:0]                    key_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [5:0]                    held_keys
);
    localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(PREFIX_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LOAD     = GW'(GAP_CYCLES - 1);

    parseState_t   parseState;
    logic [TW-1:0] timeoutCount;
    logic [GW-1:0] gapCount;

    logic          keyEvent;
    logic          keyIsBreak;
    logic          keyIsExt;
    keyHit_t       hit;
    logic          makeNew;
    logic          fifoPop;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [7:0]    fifoHead;

    // Classify the incoming byte: prefix bytes only move the parser, any
    // other byte completes a make or break event.
    always_comb begin
        keyEvent   = 1'b0;
        keyIsBreak = 1'b0;
        keyIsExt   = 1'b0;
        if (ps2_key_pressed) begin
            case (parseState)
                ST_IDLE: begin
                    keyEvent = (ps2_key_data != SC_EXT) && (ps2_key_data != SC_BRK);
                end
                ST_EXT: begin
                    keyEvent = (ps2_key_data != SC_EXT) && (ps2_key_data != SC_BRK);
                    keyIsExt = 1'b1;
                end
                ST_BRK: begin
                    keyEvent   = 1'b1;
                    keyIsBreak = 1'b1;
                end
                default: begin
                    keyEvent   = 1'b1;
                    keyIsBreak = 1'b1;
                    keyIsExt   = 1'b1;
                end
            endcase
        end
    end

    assign hit = lookupKey(keyIsExt, ps2_key_data);

    // Only the first make of a key while it is released reaches the buffer.
    assign makeNew = keyEvent && !keyIsBreak && hit.hit && !held_keys[hit.idx];
    assign fifoPop = !fifoEmpty && accept_en && (gapCount == '0);

    ps2_key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) keyFifo (
        .clock   (clock),
        .reset   (reset),
        .push    (makeNew),
        .pop     (fifoPop),
        .dataIn  (keyCode(hit.idx)),
        .dataOut (fifoHead),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .count   (fifo_count)
    );

    // Parser FSM. The timeout counter restarts on every byte and only runs
    // while a prefix is pending, so a lost byte cannot wedge the parser.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parseState   <= ST_IDLE;
            timeoutCount <= '0;
        end else if (ps2_key_pressed) begin
            timeoutCount <= '0;
            case (parseState)
                ST_IDLE: begin
                    if (ps2_key_data == SC_EXT) begin
                        parseState <= ST_EXT;
                    end else if (ps2_key_data == SC_BRK) begin
                        parseState <= ST_BRK;
                    end else begin
                        parseState <= ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (ps2_key_data == SC_BRK) begin
                        parseState <= ST_EXT_BRK;
                    end else if (ps2_key_data == SC_EXT) begin
                        parseState <= ST_EXT;
                    end else begin
                        parseState <= ST_IDLE;
                    end
                end
                default: parseState <= ST_IDLE;
            endcase
        end else if (parseState != ST_IDLE) begin
            if (timeoutCount == TIMEOUT_LAST) begin
                parseState   <= ST_IDLE;
                timeoutCount <= '0;
            end else begin
                timeoutCount <= timeoutCount + TW'(1);
            end
        end
    end

    // Held-key tracking, overflow flag and the paced issue of buffered keys.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            held_keys   <= '0;
            overflow    <= 1'b0;
            key_pressed <= 1'b0;
            key_data    <= '0;
            gapCount    <= '0;
        end else begin
            key_pressed <= fifoPop;
            if (fifoPop) begin
                key_data <= fifoHead;
                gapCount <= GAP_LOAD;
            end else if (gapCount != '0) begin
                gapCount <= gapCount - GW'(1);
            end
            // The held bit is set even when the push is dropped, so the
            // repeats of a dropped key stay suppressed until it is released.
            if (keyEvent && hit.hit) begin
                held_keys[hit.idx] <= !keyIsBreak;
            end
            if (makeNew && fifoFull && !fifoPop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_filter.sv
`timescale 1ns/1ps
module tb_ps2_key_filter;
    localparam int DEPTH = 4;
    localparam int GAP   = 16;
    localparam int PT    = 64;
`ifdef PS2_WASD_EN
    localparam int WASD = 1;
`else
    localparam int WASD = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       strobe = 1'b0;
    logic [7:0] data = 8'h00;
    logic       accept_en = 1'b0;
    logic       key_pressed;
    logic [7:0] key_data;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [5:0] held_keys;

    ps2_key_filter #(
        .FIFO_DEPTH     (DEPTH),
        .GAP_CYCLES     (GAP),
        .PREFIX_TIMEOUT (PT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ps2_key_pressed (strobe),
        .ps2_key_data    (data),
        .accept_en       (accept_en),
        .key_pressed     (key_pressed),
        .key_data        (key_data),
        .fifo_count      (fifo_count),
        .overflow        (overflow),
        .held_keys       (held_keys)
    );

    always #10 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Every observed key_pressed cycle is logged as one transaction.
    int         pulseCyc[$];
    logic [7:0] pulseData[$];
    always @(negedge clock) begin
        if (key_pressed === 1'b1) begin
            pulseCyc.push_back(cyc);
            pulseData.push_back(key_data);
            $display("pulse cyc=%0d key=%02h count=%0d held=%06b", cyc, key_data, fifo_count, held_keys);
        end
    end

    int nChecks = 0;
    int nFail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (byte-stream level) -----------------
    logic [7:0] codes [6] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h76};
    logic       mExt, mBrk, mOvf;
    logic [5:0] mHeld;
    logic [7:0] mQ[$];
    int         mLastCyc;

    function automatic int keyIdx(input logic ext, input logic [7:0] code);
        if (ext) begin
            case (code)
                8'h75: return 0;
                8'h72: return 1;
                8'h6B: return 2;
                8'h74: return 3;
                default: return -1;
            endcase
        end
        case (code)
            8'h5A: return 4;
            8'h76: return 5;
`ifdef PS2_WASD_EN
            8'h1D: return 0;
            8'h1B: return 1;
            8'h1C: return 2;
            8'h23: return 3;
`endif
            default: return -1;
        endcase
    endfunction

    task automatic modelReset();
        mExt = 1'b0; mBrk = 1'b0; mOvf = 1'b0; mHeld = '0; mLastCyc = 0;
        mQ.delete();
    endtask

    task automatic modelByte(input logic [7:0] b);
        int k;
        // A pending prefix is abandoned after PT byte-free clocks.
        if (cyc - mLastCyc - 1 >= PT) begin
            mExt = 1'b0; mBrk = 1'b0;
        end
        mLastCyc = cyc;
        if (!mBrk && b == 8'hE0) mExt = 1'b1;
        else if (!mBrk && b == 8'hF0) mBrk = 1'b1;
        else begin
            k = keyIdx(mExt, b);
            if (k >= 0) begin
                if (mBrk) mHeld[k] = 1'b0;
                else if (!mHeld[k]) begin
                    mHeld[k] = 1'b1;
                    if (mQ.size() < DEPTH) mQ.push_back(codes[k]);
                    else mOvf = 1'b1;
                end
            end
            mExt = 1'b0; mBrk = 1'b0;
        end
    endtask

    // ---------------- stimulus helpers (called at a negedge) ---------------
    task automatic sendByte(input logic [7:0] b);
        strobe = 1'b1;
        data   = b;
        modelByte(b);
        @(negedge clock);
        strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic doReset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic clearPulses();
        pulseCyc.delete();
        pulseData.delete();
    endtask

    function automatic int pCyc(input int i);
        return (i < pulseCyc.size()) ? pulseCyc[i] : -1;
    endfunction

    function automatic logic [7:0] pData(input int i);
        return (i < pulseData.size()) ? pulseData[i] : 8'hXX;
    endfunction

    function automatic logic [7:0] pickByte();
        logic [7:0] pool [8] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h76, 8'h1D, 8'h23};
        int r = int'($urandom_range(0, 15));
        if (r <= 3) return 8'hE0;
        if (r <= 6) return 8'hF0;
        if (r <= 14) return pool[r - 7];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int t;
        int n;
        int exp;
        modelReset();

        // Reset state
        idle(3);
        chk("rst_key_pressed", key_pressed, 0);
        chk("rst_key_data", key_data, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_held", held_keys, 0);
        reset = 1'b0;
        modelReset();

        // Latency of a single extended make
        accept_en = 1'b1;
        clearPulses();
        sendByte(8'hE0);
        t = cyc;
        sendByte(8'h75);
        idle(6);
        chk("lat_pulses", pulseCyc.size(), 1);
        chk("lat_cycle", pCyc(0), t + 2);
        chk("lat_data", pData(0), 8'h75);
        chk("lat_held", held_keys, 6'b000001);
        chk("lat_data_hold", key_data, 8'h75);

        // Typematic repeats then release
        doReset();
        clearPulses();
        repeat (5) begin
            sendByte(8'hE0);
            sendByte(8'h75);
        end
        sendByte(8'hE0);
        sendByte(8'hF0);
        sendByte(8'h75);
        idle(40);
        chk("typ_pulses", pulseCyc.size(), 1);
        chk("typ_data", pData(0), 8'h75);
        chk("typ_held", held_keys, 0);

        // Overflow with consumer busy, then paced drain
        doReset();
        accept_en = 1'b0;
        clearPulses();
        foreach (codes[i]) begin
            if (i < 4) begin
                sendByte(8'hE0); sendByte(codes[i]);
                sendByte(8'hE0); sendByte(8'hF0); sendByte(codes[i]);
            end else if (i == 4) begin
                sendByte(codes[i]);
                sendByte(8'hF0); sendByte(codes[i]);
            end
        end
        idle(3);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_held", held_keys, 0);
        chk("ovf_no_pulse", pulseCyc.size(), 0);
        accept_en = 1'b1;
        idle(4 * GAP + 10);
        chk("drain_pulses", pulseCyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_data%0d", i), pData(i), codes[i]);
            if (i > 0) chk($sformatf("drain_gap%0d", i), (pCyc(i) - pCyc(i-1)) >= GAP, 1);
        end
        chk("drain_count", fifo_count, 0);
        chk("drain_ovf_sticky", overflow, 1);

        // Prefix timeout, and a byte arriving before the timeout
        doReset();
        clearPulses();
        sendByte(8'hE0);
        idle(PT + 5);
        sendByte(8'h75);
        idle(20);
        chk("tmo_pulses", pulseCyc.size(), 0);
        chk("tmo_held", held_keys, 0);
        sendByte(8'hE0);
        idle(10);
        sendByte(8'h75);
        idle(6);
        chk("pre_tmo_pulses", pulseCyc.size(), 1);
        chk("pre_tmo_data", pData(0), 8'h75);

        // Reset right after a break prefix
        doReset();
        clearPulses();
        sendByte(8'hF0);
        doReset();
        sendByte(8'h76);
        idle(6);
        chk("rstbrk_pulses", pulseCyc.size(), 1);
        chk("rstbrk_data", pData(0), 8'h76);
        chk("rstbrk_held", held_keys, 6'b100000);

        // WASD alias
        doReset();
        clearPulses();
        sendByte(8'h1D);
        idle(6);
        chk("wasd_pulses", pulseCyc.size(), WASD);
        chk("wasd_held", held_keys, WASD);
        if (pulseCyc.size() > 0) chk("wasd_data", pData(0), 8'h75);

        // Randomised rounds: fill with consumer busy, then drain
        for (int round = 0; round < 10; round++) begin
            if (round % 3 == 0) doReset();
            accept_en = 1'b0;
            clearPulses();
            mQ.delete();
            n = int'($urandom_range(6, 24));
            for (int j = 0; j < n; j++) begin
                sendByte(pickByte());
                idle(int'($urandom_range(0, 3)));
            end
            idle(2);
            chk($sformatf("rnd%0d_held", round), held_keys, mHeld);
            chk($sformatf("rnd%0d_count", round), fifo_count, mQ.size());
            chk($sformatf("rnd%0d_ovf", round), overflow, mOvf);
            exp = mQ.size();
            accept_en = 1'b1;
            idle(exp * GAP + 20);
            chk($sformatf("rnd%0d_pulses", round), pulseCyc.size(), exp);
            for (int i = 0; i < exp; i++) begin
                chk($sformatf("rnd%0d_data%0d", round, i), pData(i), mQ[i]);
                if (i > 0) chk($sformatf("rnd%0d_gap%0d", round, i), (pCyc(i) - pCyc(i-1)) >= GAP, 1);
            end
            chk($sformatf("rnd%0d_empty", round), fifo_count, 0);
            mQ.delete();
        end

        $display("%0d/%0d checks passed", nChecks - nFail, nChecks);
        $finish;
    end

endmodule
